// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator: valid/ready command in, APB SETUP/ACCESS
// transfer out, registered response with PSLVERR capture and PREADY timeout.
module apb_master_bridge #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]               cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      state;
  logic [15:0] wait_cnt;
  logic        timed_out;

  // Counter equals the index of the current ACCESS cycle, so a stuck slave
  // sees TIMEOUT_CYCLES+1 ACCESS cycles before the abort.
  assign timed_out = (TIMEOUT_CYCLES != 0) && (wait_cnt == TIMEOUT_LIMIT);
  assign cmd_ready = HRESETn && (state == IDLE);

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            PADDR  <= cmd_addr;
            PWRITE <= cmd_write;
            PWDATA <= cmd_write ? cmd_wdata : '0;
            PSEL   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            state       <= RESP;
          end else if (timed_out) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            state       <= RESP;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: table of transfers plus a reset-abort sequence.
module tb_apb_master_bridge;

  localparam int unsigned AW  = 12;
  localparam int unsigned TMO = 4;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid, rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err, rsp_timeout;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA, PRDATA;
  logic          PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

  apb_master_bridge #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    int unsigned   waits;     // ACCESS cycles with PREADY low before PREADY high
    logic [31:0]   prdata;
    logic          slverr;
    int unsigned   hold;      // cycles rsp_ready is held low
    logic [31:0]   exp_rdata;
    logic          exp_err;
    logic          exp_timeout;
    int unsigned   exp_access;
  } vec_t;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic run_xfer(input vec_t v);
    int unsigned i;
    bit done;
    @(negedge HCLK);
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
    @(negedge HCLK);
    cmd_valid = 1'b0; cmd_wdata = 32'hBAD0_BAD0; cmd_addr = ~v.addr;
    check("setup_psel", 32'(PSEL), 32'd1);
    check("setup_penable", 32'(PENABLE), 32'd0);
    check("setup_cmd_ready", 32'(cmd_ready), 32'd0);
    check("setup_paddr", 32'(PADDR), 32'(v.addr));
    check("setup_pwrite", 32'(PWRITE), 32'(v.write));
    check("setup_pwdata", PWDATA, v.write ? v.wdata : 32'd0);
    i = 0; done = 1'b0;
    while (!done && i < 20) begin
      @(negedge HCLK);
      check("access_psel", 32'(PSEL), 32'd1);
      check("access_penable", 32'(PENABLE), 32'd1);
      check("access_paddr", 32'(PADDR), 32'(v.addr));
      check("access_pwdata", PWDATA, v.write ? v.wdata : 32'd0);
      if (i == v.waits) begin
        PREADY = 1'b1; PRDATA = v.prdata; PSLVERR = v.slverr;
      end else begin
        PREADY = 1'b0; PRDATA = ~v.prdata; PSLVERR = 1'b1;
      end
      if (i == v.waits || i == TMO) done = 1'b1;
      i++;
    end
    check("access_cycles", i, v.exp_access);
    @(negedge HCLK);
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0;
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_psel_low", 32'(PSEL), 32'd0);
    check("rsp_penable_low", 32'(PENABLE), 32'd0);
    check("rsp_rdata", rsp_rdata, v.exp_rdata);
    check("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    check("rsp_timeout", 32'(rsp_timeout), 32'(v.exp_timeout));
    if (v.hold > 0) begin
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h7F0;
      for (int unsigned h = 0; h < v.hold; h++) begin
        @(negedge HCLK);
        check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
        check("hold_rsp_rdata", rsp_rdata, v.exp_rdata);
        check("hold_rsp_err", 32'(rsp_err), 32'(v.exp_err));
        check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        check("hold_psel", 32'(PSEL), 32'd0);
      end
      cmd_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge HCLK);
    rsp_ready = 1'b0;
    check("done_rsp_valid", 32'(rsp_valid), 32'd0);
    check("done_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  vec_t vecs[7];

  initial begin
    // write, addr, wdata, waits, prdata, slverr, hold, exp_rdata, exp_err, exp_to, exp_access
    vecs[0] = '{1'b1, 12'h114, 32'h0000_0001, 0,  32'h0,         1'b0, 0,  32'h0,         1'b0, 1'b0, 1};
    vecs[1] = '{1'b0, 12'h100, 32'hFFFF_FFFF, 3,  32'h0005_0003, 1'b0, 10, 32'h0005_0003, 1'b0, 1'b0, 4};
    vecs[2] = '{1'b1, 12'h200, 32'hDEAD_BEEF, 0,  32'h1111_2222, 1'b1, 0,  32'h0,         1'b1, 1'b0, 1};
    vecs[3] = '{1'b0, 12'h0FF, 32'h0,         99, 32'h0000_1234, 1'b0, 0,  32'h0,         1'b1, 1'b1, 5};
    vecs[4] = '{1'b0, 12'h0AA, 32'h0,         4,  32'h0000_CAFE, 1'b0, 0,  32'h0000_CAFE, 1'b0, 1'b0, 5};
    vecs[5] = '{1'b1, 12'h3FC, 32'h5A5A_A5A5, 99, 32'h0,         1'b0, 2,  32'h0,         1'b1, 1'b1, 5};
    vecs[6] = '{1'b0, 12'h010, 32'h0,         0,  32'h0000_0055, 1'b1, 0,  32'h0000_0055, 1'b1, 1'b0, 1};

    HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (3) @(negedge HCLK);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset_psel", 32'(PSEL), 32'd0);
    check("reset_penable", 32'(PENABLE), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_paddr", 32'(PADDR), 32'd0);
    check("reset_pwdata", PWDATA, 32'd0);
    check("reset_pwrite", 32'(PWRITE), 32'd0);
    check("reset_rsp_fields", {rsp_rdata[30:0], rsp_err}, 32'd0);
    HRESETn = 1'b1;

    for (int k = 0; k < 7; k++) run_xfer(vecs[k]);

    // Reset during ACCESS of a read drops the transfer without a response.
    @(negedge HCLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h300;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    @(negedge HCLK);
    check("abort_in_access", 32'(PENABLE), 32'd1);
    HRESETn = 1'b0;
    @(negedge HCLK);
    check("abort_psel", 32'(PSEL), 32'd0);
    check("abort_penable", 32'(PENABLE), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd0);
    check("abort_paddr", 32'(PADDR), 32'd0);
    HRESETn = 1'b1;
    @(negedge HCLK);
    check("post_abort_rsp_valid", 32'(rsp_valid), 32'd0);
    run_xfer('{1'b1, 12'h10C, 32'h0000_0032, 0, 32'h0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
